cpu_busarb: RTL and testbench
=============================

# cpu_busarb

Clocked arbiter and sequencer that shares the single 16-bit CPU memory bus between the instruction-fetch port and the load/store port. It grants one requester at a time and drives registered bus strobes. It waits out `needWait_i` wait states and returns a one-cycle acknowledge with captured read data. It adds mem-over-fetch priority with a fetch anti-starvation guard and a wait-state timeout that aborts hung accesses.

## Interface
- `MAX_MEM_BURST`, 4: consecutive contested mem grants before fetch is forced through (1..15).
- `WAIT_TIMEOUT`, 255: wait-state cycles before abort (1..255); 0 disables the timeout.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  fetch read request; held with `fetch_addr` stable until `fetch_ack`.
- `fetch_addr`  in  16  fetch address.
- `fetch_ack`  out  1  one-cycle completion pulse for fetch.
- `mem_req`  in  1  load/store request; held with addr/we/wdata stable until `mem_ack`.
- `mem_addr`  in  16  load/store address.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_wdata`  in  16  write data.
- `mem_ack`  out  1  one-cycle completion pulse for mem.
- `rdata`  out  16  read data; valid while either ack is high.
- `bus_err`  out  1  high with ack when the access was aborted by timeout.
- `busy_o`  out  1  high in any state other than IDLE.
- `addr_o`  out  16  bus address (registered).
- `re_o`  out  1  bus read strobe (registered).
- `we_o`  out  1  bus write strobe (registered); also the data output enable.
- `data_o`  out  16  bus write data (registered).
- `data_i`  in  16  bus read data.
- `needWait_i`  in  1  bus slave requests a wait state in the current cycle.

## Operation
- States: IDLE, BUSY_F, BUSY_M, DONE.
- IDLE: all bus outputs are 0. On an edge with any req high, pick a winner, load `addr_o`/`re_o`/`we_o`/`data_o`, and go to BUSY_F or BUSY_M.
  - `re_o = ~mem_we` for mem and 1 for fetch.
  - `data_o = mem_wdata` only for mem writes, else 0.
- Arbitration when both requests are high:
  - mem wins, unless `streak == MAX_MEM_BURST`, in which case fetch wins.
  - `streak` is a 4-bit counter. It increments, saturating, on each mem grant made while `fetch_req` is high. It clears on every fetch grant.
  - A sole requester always wins; a sole mem grant leaves `streak` unchanged.
- BUSY_x: the bus outputs hold.
  - Edge with `needWait_i` = 0: capture `data_i` into `rdata` (write: `rdata` = 0), clear the bus outputs, go to DONE, and set the winner's ack.
  - Edge with `needWait_i` = 1: `wcnt` (8-bit) increments.
    - If `WAIT_TIMEOUT` != 0 and `wcnt + 1 == WAIT_TIMEOUT`: abort. Clear the bus outputs, set `rdata = 16'hFFFF`, set ack and `bus_err`, go to DONE.
- `wcnt` clears on entry to BUSY_x.
- DONE: ack (and `bus_err` if aborted) is high for exactly this cycle. Requests are ignored here, so a requester still holding its old req is not re-granted. The next edge goes to IDLE, clearing ack, `bus_err` and `rdata`.
- Never more than one of `re_o` and `we_o` is high. `fetch_ack` and `mem_ack` are never high together.
- Asynchronous reset, at any time including mid-access: state = IDLE, `streak` = `wcnt` = 0, and every output = 0. The in-flight access gets no ack; the requester retries.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Zero-wait access (req seen at edge E0):
  - E0: strobes rise (BUSY).
  - E1: `needWait_i` = 0 sampled; ack rises (DONE).
  - E2: back to IDLE.
  - E3: earliest next grant.
  - Minimum is 3 cycles per access.
- Each wait cycle adds one cycle between E0 and E1.
- A timeout abort acks exactly `WAIT_TIMEOUT` cycles after strobes rise.
- A req that drops before it is sampled in IDLE is never granted. Dropping a req while in BUSY is illegal and undefined.

## Test plan
- Fetch read, zero wait: `fetch_req`=1, `fetch_addr`=0x1234, `data_i`=0xBEEF -> `re_o`=1 and `addr_o`=0x1234 for 1 cycle; the next cycle `fetch_ack`=1 and `rdata`=0xBEEF; `busy_o` falls 2 cycles after `re_o` rose.
- Mem write with 3 wait states: `mem_we`=1, `mem_addr`=0x0040, `mem_wdata`=0x5A5A -> `we_o`=1 and `data_o`=0x5A5A held 4 cycles; `mem_ack`=1 with `rdata`=0 and `bus_err`=0.
- Contention fairness, `MAX_MEM_BURST`=4, both reqs held continuously -> grant order M,M,M,M,F,M,M,M,M,F; no `fetch_ack`/`mem_ack` overlap.
- Timeout, `WAIT_TIMEOUT`=8, `needWait_i` stuck at 1 -> `re_o` high exactly 8 cycles, then `mem_ack`=1, `bus_err`=1, `rdata`=0xFFFF for 1 cycle, then IDLE. With `WAIT_TIMEOUT`=0 the access waits for 300+ cycles with no ack.
- Stale req: requester drops req only after seeing ack -> no duplicate grant in DONE; the next grant is 2 cycles after ack.
- Reset mid-access: `reset_n` low while in BUSY_M with `we_o`=1 -> all outputs are 0 immediately, with no ack; after release, a re-issued request completes normally and `streak` restarts from 0.

Source files
------------

// File: rtl/cpu_busarb.sv
// cpu_busarb: shares the single 16-bit CPU memory bus between the instruction-fetch
// port and the load/store port. One requester is granted at a time. Bus strobes are
// registered. Wait states requested by the slave are honoured, and hung accesses are
// aborted after a configurable timeout. Load/store has priority over fetch, except
// that fetch is forced through after MAX_MEM_BURST consecutive contested mem grants.
//
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   fetch_req/fetch_addr         fetch read request; fetch_ack is its completion pulse
//   mem_req/addr/we/wdata        load/store request; mem_ack is its completion pulse
//   rdata, bus_err               read data and abort flag, valid while an ack is high
//   busy_o                       arbiter is not idle
//   addr_o/re_o/we_o/data_o      registered bus address, strobes and write data
//   data_i, needWait_i           bus read data and slave wait-state request
module cpu_busarb #(
  parameter int unsigned MAX_MEM_BURST = 4,
  parameter int unsigned WAIT_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  input  logic        mem_req,
  input  logic [15:0] mem_addr,
  input  logic        mem_we,
  input  logic [15:0] mem_wdata,
  output logic        mem_ack,
  output logic [15:0] rdata,
  output logic        bus_err,
  output logic        busy_o,
  output logic [15:0] addr_o,
  output logic        re_o,
  output logic        we_o,
  output logic [15:0] data_o,
  input  logic [15:0] data_i,
  input  logic        needWait_i
);

  localparam logic [3:0] MaxBurst   = 4'(MAX_MEM_BURST);
  localparam logic [8:0] TimeoutCnt = 9'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusyF, StBusyM, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [15:0] addr_q, addr_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic [15:0] data_q, data_d;
  logic [15:0] rdata_q, rdata_d;
  logic        fetch_ack_q, fetch_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic        bus_err_q, bus_err_d;
  logic        grant_fetch;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wcnt_d      = wcnt_q;
    addr_d      = addr_q;
    re_d        = re_q;
    we_d        = we_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    fetch_ack_d = fetch_ack_q;
    mem_ack_d   = mem_ack_q;
    bus_err_d   = bus_err_q;
    grant_fetch = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fetch_req || mem_req) begin
          // Fetch wins when alone, or when mem has used up its contested burst.
          grant_fetch = fetch_req && (!mem_req || (streak_q == MaxBurst));
          wcnt_d      = 8'd0;
          if (grant_fetch) begin
            state_d  = StBusyF;
            addr_d   = fetch_addr;
            re_d     = 1'b1;
            we_d     = 1'b0;
            data_d   = 16'h0000;
            streak_d = 4'd0;
          end else begin
            state_d = StBusyM;
            addr_d  = mem_addr;
            re_d    = ~mem_we;
            we_d    = mem_we;
            data_d  = mem_we ? mem_wdata : 16'h0000;
            // Only contested mem grants count toward the burst limit.
            if (fetch_req && (streak_q != 4'hF)) begin
              streak_d = streak_q + 4'd1;
            end
          end
        end
      end

      StBusyF, StBusyM: begin
        if (!needWait_i) begin
          rdata_d     = we_q ? 16'h0000 : data_i;
          addr_d      = 16'h0000;
          re_d        = 1'b0;
          we_d        = 1'b0;
          data_d      = 16'h0000;
          fetch_ack_d = (state_q == StBusyF);
          mem_ack_d   = (state_q == StBusyM);
          state_d     = StDone;
        end else begin
          if (wcnt_q != 8'hFF) begin
            wcnt_d = wcnt_q + 8'd1;
          end
          if ((TimeoutCnt != 9'd0) && (({1'b0, wcnt_q} + 9'd1) == TimeoutCnt)) begin
            rdata_d     = 16'hFFFF;
            addr_d      = 16'h0000;
            re_d        = 1'b0;
            we_d        = 1'b0;
            data_d      = 16'h0000;
            fetch_ack_d = (state_q == StBusyF);
            mem_ack_d   = (state_q == StBusyM);
            bus_err_d   = 1'b1;
            state_d     = StDone;
          end
        end
      end

      StDone: begin
        // Requests are deliberately ignored here so a held req is not re-granted.
        fetch_ack_d = 1'b0;
        mem_ack_d   = 1'b0;
        bus_err_d   = 1'b0;
        rdata_d     = 16'h0000;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      streak_q    <= 4'd0;
      wcnt_q      <= 8'd0;
      addr_q      <= 16'h0000;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      data_q      <= 16'h0000;
      rdata_q     <= 16'h0000;
      fetch_ack_q <= 1'b0;
      mem_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      re_q        <= re_d;
      we_q        <= we_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      fetch_ack_q <= fetch_ack_d;
      mem_ack_q   <= mem_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign fetch_ack = fetch_ack_q;
  assign mem_ack   = mem_ack_q;
  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;
  assign busy_o    = (state_q != StIdle);
  assign addr_o    = addr_q;
  assign re_o      = re_q;
  assign we_o      = we_q;
  assign data_o    = data_q;

endmodule

// File: tb/tb_cpu_busarb.sv
// Bench for cpu_busarb: table of single zero-wait accesses plus hand sequences for
// wait states, contention fairness, timeout, stale request, reset mid-access and a
// second instance with the timeout disabled.
module tb_cpu_busarb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0;
  logic        mem_req = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_wdata = 16'h0;
  logic [15:0] data_i = 16'h0;
  logic        needWait_i = 1'b0;

  logic        fetch_ack, mem_ack, bus_err, busy_o, re_o, we_o;
  logic [15:0] rdata, addr_o, data_o;
  logic        nt_fetch_ack, nt_mem_ack, nt_bus_err, nt_busy, nt_re, nt_we;
  logic [15:0] nt_rdata, nt_addr, nt_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_busarb #(.MAX_MEM_BURST(4), .WAIT_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .rdata(rdata), .bus_err(bus_err), .busy_o(busy_o),
    .addr_o(addr_o), .re_o(re_o), .we_o(we_o), .data_o(data_o),
    .data_i(data_i), .needWait_i(needWait_i)
  );

  cpu_busarb #(.MAX_MEM_BURST(4), .WAIT_TIMEOUT(0)) u_nt (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(nt_fetch_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(nt_mem_ack), .rdata(nt_rdata), .bus_err(nt_bus_err), .busy_o(nt_busy),
    .addr_o(nt_addr), .re_o(nt_re), .we_o(nt_we), .data_o(nt_data),
    .data_i(data_i), .needWait_i(needWait_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {fetch_ack, mem_ack, rdata, bus_err, busy_o, addr_o, re_o, we_o, data_o};
  endfunction

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic        exp_re;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_data_o;
    logic [15:0] exp_rdata;
  } vec_t;

  // Both requests held; records which port each grant went to (bit=1 fetch).
  task automatic contest(input int n, input logic [9:0] exp_f, input string name);
    int          got = 0;
    int          cyc = 0;
    logic [9:0]  gf = '0;
    logic        overlap = 1'b0;
    logic        prev_re = 1'b0;
    logic        acked = 1'b0;
    @(negedge clk);
    fetch_addr = 16'h1000; mem_addr = 16'h2000; mem_we = 1'b0; needWait_i = 1'b0;
    data_i = 16'h7777; fetch_req = 1'b1; mem_req = 1'b1;
    while (got < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (fetch_ack && mem_ack) overlap = 1'b1;
      if (re_o && !prev_re) begin
        gf[got] = (addr_o == 16'h1000);
        got++;
      end
      prev_re = re_o;
    end
    for (int i = 0; i < 10 && !acked; i++) begin
      @(negedge clk);
      if (fetch_ack && mem_ack) overlap = 1'b1;
      acked = fetch_ack | mem_ack;
    end
    fetch_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, "_count"}, 64'(got), 64'(n));
    chk({name, "_order"}, 64'(gf), 64'(exp_f));
    chk({name, "_overlap"}, 64'(overlap), 64'd0);
    chk({name, "_last_ack"}, 64'(acked), 64'd1);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b0, 16'h0100, 16'hAAAA, 16'h0F0F, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0F0F};
    vecs[2] = '{1'b1, 1'b1, 16'h0040, 16'h5A5A, 16'h1111, 1'b0, 1'b1, 16'h0040, 16'h5A5A, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0001};

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", all_out(), 64'd0);

    // Table of zero-wait single accesses.
    foreach (vecs[i]) begin
      @(negedge clk);
      fetch_addr = vecs[i].addr; mem_addr = vecs[i].addr; mem_we = vecs[i].we;
      mem_wdata = vecs[i].wdata; data_i = vecs[i].din; needWait_i = 1'b0;
      fetch_req = ~vecs[i].is_mem; mem_req = vecs[i].is_mem;
      @(negedge clk);
      chk($sformatf("v%0d_strobes", i), {re_o, we_o, busy_o},
          {vecs[i].exp_re, vecs[i].exp_we, 1'b1});
      chk($sformatf("v%0d_addr", i), 64'(addr_o), 64'(vecs[i].exp_addr));
      chk($sformatf("v%0d_data_o", i), 64'(data_o), 64'(vecs[i].exp_data_o));
      @(negedge clk);
      chk($sformatf("v%0d_acks", i), {fetch_ack, mem_ack, bus_err, re_o, we_o},
          {~vecs[i].is_mem, vecs[i].is_mem, 3'b000});
      chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      fetch_req = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), all_out(), 64'd0);
    end

    // Mem write with 3 wait states: we_o held 4 cycles.
    @(negedge clk);
    mem_addr = 16'h0040; mem_we = 1'b1; mem_wdata = 16'h5A5A; needWait_i = 1'b1;
    data_i = 16'h3333; mem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("ws_hold%0d", c), {we_o, re_o, data_o, addr_o, mem_ack},
          {1'b1, 1'b0, 16'h5A5A, 16'h0040, 1'b0});
    end
    needWait_i = 1'b0;
    @(negedge clk);
    chk("ws_ack", {mem_ack, fetch_ack, bus_err, we_o, rdata}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);

    contest(10, 10'h210, "fair");

    // Timeout with WAIT_TIMEOUT=8 on dut.
    begin
      int cnt = 0;
      @(negedge clk);
      mem_addr = 16'h0300; mem_we = 1'b0; needWait_i = 1'b1; data_i = 16'h4444; mem_req = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (re_o) cnt++;
        else break;
      end
      chk("to_re_cycles", 64'(cnt), 64'd8);
      chk("to_ack", {mem_ack, fetch_ack, bus_err, rdata}, {1'b1, 1'b0, 1'b1, 16'hFFFF});
      mem_req = 1'b0; needWait_i = 1'b0;
      @(negedge clk);
      chk("to_idle", all_out(), 64'd0);
    end

    // Stale req: fetch_req held through DONE is not re-granted there.
    @(negedge clk);
    fetch_addr = 16'h0800; data_i = 16'h1357; needWait_i = 1'b0; fetch_req = 1'b1;
    @(negedge clk);
    chk("stale_grant1", {re_o, addr_o}, {1'b1, 16'h0800});
    @(negedge clk);
    chk("stale_ack", {fetch_ack, rdata}, {1'b1, 16'h1357});
    @(negedge clk);
    chk("stale_no_regrant", {re_o, busy_o, fetch_ack}, 3'b000);
    @(negedge clk);
    chk("stale_grant2", {re_o, busy_o}, 2'b11);
    @(negedge clk);
    chk("stale_ack2", 64'(fetch_ack), 64'd1);
    fetch_req = 1'b0;
    @(negedge clk);

    // Build streak to 3, then reset mid mem write; streak must restart at 0.
    contest(3, 10'h000, "pre");
    @(negedge clk);
    mem_addr = 16'h0040; mem_we = 1'b1; mem_wdata = 16'h5A5A; needWait_i = 1'b1; mem_req = 1'b1;
    @(negedge clk);
    chk("rst_pre_we", {we_o, busy_o}, 2'b11);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_zero", all_out(), 64'd0);
    mem_req = 1'b0; mem_we = 1'b0; needWait_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_held_zero", all_out(), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_no_ack", {fetch_ack, mem_ack, busy_o}, 3'b000);
    contest(5, 10'h010, "post");

    // Timeout disabled instance waits 300+ cycles without ack.
    begin
      int hold = 0;
      logic seen_ack = 1'b0;
      @(negedge clk);
      mem_addr = 16'h0500; mem_we = 1'b0; needWait_i = 1'b1; data_i = 16'hC0DE; mem_req = 1'b1;
      for (int c = 0; c < 310; c++) begin
        @(negedge clk);
        if (nt_re) hold++;
        if (nt_mem_ack || nt_bus_err) seen_ack = 1'b1;
      end
      chk("nt_hold", 64'(hold), 64'd310);
      chk("nt_no_ack", 64'(seen_ack), 64'd0);
      needWait_i = 1'b0;
      @(negedge clk);
      chk("nt_ack", {nt_mem_ack, nt_bus_err, nt_rdata}, {1'b1, 1'b0, 16'hC0DE});
      mem_req = 1'b0;
      repeat (2) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
